reel_spin_controller: RTL and testbench
=======================================

Name: reel_spin_controller

Overview:
- Consumer end of the RNG number stream. On a player spin request, samples the free-running RNG value once and converts it into a reel spin length.
- Advances the reel symbol at a fixed divided rate, then stops and presents the final symbol with a valid/ready handshake.
- One instance per reel. It sits between the RNG and the payout/scoring logic.

Parameters:
- N_SYMBOLS, 6, number of reel symbols; positions 0..N_SYMBOLS-1; need not be a power of two.
- SYM_W, $clog2(N_SYMBOLS), width of symbol/position values.
- RNG_W, 4, width of the sampled RNG value.
- MIN_STEPS, 12, minimum reel advances per spin; must satisfy 1 <= MIN_STEPS < 2^RNG_W.
- STEP_DIV, 4, clock cycles per reel advance; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rnd  input  RNG_W  current RNG output; sampled only at spin acceptance.
- spin_req  input  1  player spin request; level-sensitive.
- spin_ack  output  1  one-cycle pulse confirming acceptance.
- busy  output  1  high whenever state != IDLE.
- reel_pos  output  SYM_W  currently displayed symbol; drives the reel display.
- result  output  SYM_W  final stopped symbol; valid when result_valid=1.
- result_valid  output  1  result handshake valid.
- result_ready  input  1  result handshake ready from downstream.

Behaviour:
- Reset (rst=0, async): state=IDLE. reel_pos, result, result_valid, spin_ack, busy, step counter and prescaler all go to 0 immediately. Reset mid-spin abandons the spin with no result produced.
- All outputs are registered; busy is decoded from the registered state.
- States are IDLE, SPIN, DONE.
- IDLE:
  - At edge E0 with spin_req=1: load steps_left = MIN_STEPS + rnd, zero-extended to RNG_W+1 bits with no overflow possible.
  - Also at E0: prescaler=0, state=SPIN, spin_ack=1 for exactly the cycle after E0.
- SPIN:
  - The prescaler counts 0..STEP_DIV-1.
  - At each edge where prescaler==STEP_DIV-1:
    - reel_pos advances by 1, wrapping N_SYMBOLS-1 -> 0 by compare, not by bit truncation.
    - steps_left decrements.
    - The prescaler returns to 0.
  - The first advance happens at E0+STEP_DIV. The final advance happens at E0+S*STEP_DIV, where S = MIN_STEPS + rnd.
  - At that final edge: result = post-advance reel_pos, result_valid=1, state=DONE.
  - Final symbol = (reel_pos_at_E0 + S) mod N_SYMBOLS.
- DONE:
  - result and result_valid stay stable until result_ready=1 at an edge. At that edge: result_valid=0, state=IDLE.
  - result keeps its last value until the next spin completes.
- spin_req is ignored in SPIN and DONE; no spin_ack, no queuing.
- If result_ready and spin_req are both high in DONE: only the handshake completes. The new spin can be accepted no earlier than the following edge (no IDLE bypass).
- rnd changes outside the acceptance edge have no effect.
- reel_pos holds its value between spins. The next spin starts from the last stopped position.
- STEP_DIV=1: the prescaler is a constant 0 and the reel advances every cycle.

Decomposition:
- Shared package slot_pkg holds:
  - state typedef: enum logic [1:0] {IDLE, SPIN, DONE}.
  - helper function for modulo-N increment of symbol positions, reused by other reels and the display.
- One natural sub-module: spin_prescaler (parameter STEP_DIV; inputs clk, rst, clear, enable; output tick). Its counter generates the advance strobe.
- The FSM, step counter and reel position stay in reel_spin_controller.

Test Plan:
- Reset, then rnd=5 and spin_req high for 1 cycle -> spin_ack high for exactly 1 cycle after acceptance. result_valid rises 68 cycles after acceptance (S=17, STEP_DIV=4) with result=5. busy stays high from acceptance until the handshake.
- From pos 5, rnd=0 -> S=12. reel_pos must step 5->0 (wrap observed). Final result = (5+12) mod 6 = 5.
- Hold result_ready=0 for 10 cycles in DONE, with spin_req pulsed during DONE -> result and result_valid stable, no spin_ack. Then raise result_ready -> IDLE next cycle, result_valid=0.
- Drive rst low asynchronously after the 7th advance -> every output is 0 before the next clock edge. After release, rnd=3 spin -> result = 15 mod 6 = 3.
- rnd=15 (max) -> S=27, no counter overflow, result_valid 108 cycles after acceptance, result = 27 mod 6 = 3.
- Toggle rnd every cycle during SPIN -> result equals the value predicted from rnd at the acceptance edge only.

Source files
------------

// File: rtl/slot_pkg.sv
// slot_pkg: shared reel state encoding and symbol-position arithmetic.
package slot_pkg;
  typedef enum logic [1:0] {IDLE, SPIN, DONE} state_t;
  function automatic int unsigned mod_inc(input int unsigned pos, input int unsigned n);
    return (pos == n - 1) ? 0 : pos + 1;
  endfunction
endpackage

// File: rtl/spin_prescaler.sv
// spin_prescaler: divides clk by STEP_DIV into a one-cycle tick while enabled.
module spin_prescaler #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = enable && (cnt_q == CW'(STEP_DIV - 1));
    cnt_d = clear ? '0 : (enable ? (tick ? '0 : cnt_q + CW'(1)) : cnt_q);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/reel_spin_controller.sv
// reel_spin_controller: samples the RNG on a spin request, advances the reel
// S = MIN_STEPS + rnd times at the divided rate, then offers the stopped symbol.
module reel_spin_controller
  import slot_pkg::*;
#(
  parameter int N_SYMBOLS = 6,
  parameter int SYM_W     = $clog2(N_SYMBOLS),
  parameter int RNG_W     = 4,
  parameter int MIN_STEPS = 12,
  parameter int STEP_DIV  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RNG_W-1:0] rnd,
  input  logic             spin_req,
  output logic             spin_ack,
  output logic             busy,
  output logic [SYM_W-1:0] reel_pos,
  output logic [SYM_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);
  state_t           state_q, state_d;
  logic [RNG_W:0]   steps_q, steps_d;
  logic [SYM_W-1:0] pos_q, pos_d, result_q, result_d;
  logic             valid_q, valid_d, ack_q, ack_d, clear, tick;
  spin_prescaler #(.STEP_DIV(STEP_DIV)) u_pre (
    .clk(clk), .rst(rst), .clear(clear), .enable(state_q == SPIN), .tick(tick)
  );
  always_comb begin
    state_d  = state_q;
    steps_d  = steps_q;
    pos_d    = pos_q;
    result_d = result_q;
    valid_d  = valid_q;
    ack_d    = 1'b0;
    clear    = 1'b0;
    case (state_q)
      IDLE: if (spin_req) begin
        steps_d = (RNG_W+1)'(MIN_STEPS) + {1'b0, rnd};
        clear   = 1'b1;
        ack_d   = 1'b1;
        state_d = SPIN;
      end
      SPIN: if (tick) begin
        pos_d   = SYM_W'(mod_inc(32'(pos_q), N_SYMBOLS));
        steps_d = steps_q - (RNG_W+1)'(1);
        if (steps_q == (RNG_W+1)'(1)) begin
          result_d = pos_d;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: if (result_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      steps_q  <= '0;
      pos_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      steps_q  <= steps_d;
      pos_q    <= pos_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
    end
  assign busy         = (state_q != IDLE);
  assign spin_ack     = ack_q;
  assign reel_pos     = pos_q;
  assign result       = result_q;
  assign result_valid = valid_q;
endmodule

// File: tb/tb_reel_spin_controller.sv
// tb_reel_spin_controller: directed scenarios plus random traffic checked every cycle
// against a timeline model (spin start time, start position, step count).
module tb_reel_spin_controller;
  localparam int N = 6, SW = 3, RW = 4, MINS = 12, D = 4;
  logic clk = 0, rst = 0, spin_req = 0, result_ready = 0;
  logic [RW-1:0] rnd = '0;
  logic spin_ack, busy, result_valid;
  logic [SW-1:0] reel_pos, result;
  int errs = 0, checks = 0;
  bit chk_en = 0, saw_wrap = 0;
  logic [SW-1:0] prev_pos = '0;

  reel_spin_controller #(.N_SYMBOLS(N), .SYM_W(SW), .RNG_W(RW), .MIN_STEPS(MINS), .STEP_DIV(D)) dut (
    .clk(clk), .rst(rst), .rnd(rnd), .spin_req(spin_req), .spin_ack(spin_ack), .busy(busy),
    .reel_pos(reel_pos), .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // model: a spin is fully described by when it was accepted, where it started and S
  int cyc = 0, m_acc = 0, m_s = 0, m_start = 0, m_last_pos = 0, m_last_res = 0;
  bit m_active = 0;
  function automatic int m_k();
    return cyc - m_acc - 1;
  endfunction
  function automatic int m_adv();
    int a;
    a = m_k() / D;
    return (a > m_s) ? m_s : a;
  endfunction
  function automatic bit m_done();
    return m_active && (m_adv() == m_s);
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) begin
      cyc <= 0; m_acc <= 0; m_s <= 0; m_start <= 0;
      m_last_pos <= 0; m_last_res <= 0; m_active <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!m_active && spin_req) begin
        m_active <= 1; m_acc <= cyc; m_s <= MINS + int'(rnd); m_start <= m_last_pos;
      end else if (m_done() && result_ready) begin
        m_active <= 0;
        m_last_pos <= (m_start + m_s) % N;
        m_last_res <= (m_start + m_s) % N;
      end
    end

  always @(negedge clk)
    if (rst && chk_en) begin
      chk("ack", 32'(spin_ack), 32'(m_active && m_k() == 0));
      chk("busy", 32'(busy), 32'(m_active));
      chk("reel_pos", 32'(reel_pos), m_active ? 32'((m_start + m_adv()) % N) : 32'(m_last_pos));
      chk("result_valid", 32'(result_valid), 32'(m_done()));
      chk("result", 32'(result), m_done() ? 32'((m_start + m_s) % N) : 32'(m_last_res));
      if (prev_pos == 3'd5 && reel_pos == 3'd0) saw_wrap = 1;
      prev_pos = reel_pos;
    end

  task automatic all_zero(input string tag);
    chk({tag, "_pos"}, 32'(reel_pos), 0);
    chk({tag, "_res"}, 32'(result), 0);
    chk({tag, "_valid"}, 32'(result_valid), 0);
    chk({tag, "_ack"}, 32'(spin_ack), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_spin(input logic [RW-1:0] r, input int hold, output int lat, output int res);
    @(negedge clk); rnd = r; spin_req = 1;
    @(negedge clk); spin_req = 0;
    chk("ack_lit", 32'(spin_ack), 1);
    lat = 0;
    while (!result_valid && lat < 500) begin
      @(negedge clk); lat++; rnd = RW'($urandom);
    end
    if (lat >= 500) chk("valid_timeout", 0, 1);
    res = int'(result);
    repeat (hold) begin
      @(negedge clk); spin_req = 1'($urandom); result_ready = 0;
    end
    chk("held_valid", 32'(result_valid), 1);
    chk("held_res", 32'(result), 32'(res));
    spin_req = 0; result_ready = 1;
    @(negedge clk); result_ready = 0;
    chk("hs_valid", 32'(result_valid), 0);
    chk("hs_busy", 32'(busy), 0);
  endtask

  initial begin
    int lat, res;
    repeat (3) @(negedge clk);
    all_zero("rst0");
    rst = 1; chk_en = 1;
    do_spin(4'd5, 10, lat, res);
    chk("lat17", lat, 68); chk("res17", res, 5);
    saw_wrap = 0;
    do_spin(4'd0, 2, lat, res);
    chk("lat12", lat, 48); chk("res12", res, 5); chk("wrap", 32'(saw_wrap), 1);
    @(negedge clk); rnd = 4'd9; spin_req = 1;
    @(negedge clk); spin_req = 0;
    repeat (28) @(negedge clk);
    chk("pos_after7", 32'(reel_pos), 0);
    #1 rst = 0;
    #1 all_zero("async");
    @(negedge clk); @(negedge clk); rst = 1;
    do_spin(4'd3, 3, lat, res);
    chk("res15", res, 3); chk("lat15", lat, 60);
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    do_spin(4'd15, 1, lat, res);
    chk("lat27", lat, 108); chk("res27", res, 3);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      spin_req = ($urandom_range(3, 0) == 0);
      result_ready = ($urandom_range(3, 0) == 0);
      rnd = RW'($urandom);
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
